// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding and FSM states.
package lsu_pkg;

   // Access size encoding, shared with the memory-stage MemRead field.
   localparam logic [1:0] SZ_INVALID = 2'd0;
   localparam logic [1:0] SZ_BYTE    = 2'd1;
   localparam logic [1:0] SZ_HALF    = 2'd2;
   localparam logic [1:0] SZ_WORD    = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } lsu_state_e;

   // True when the access size and byte offset form an illegal combination.
   function automatic logic is_bad_align(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      unique case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational lane logic: little-endian lane extraction with sign/zero extension
// for loads, and lane insertion into a read word for sub-word stores.
module lsu_lane_unit
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic        i_signed,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed byte and half-word lanes.
   always_comb begin
      w_byte = 8'h00;
      unique case (i_offset)
         2'd0: w_byte = i_word[7:0];
         2'd1: w_byte = i_word[15:8];
         2'd2: w_byte = i_word[23:16];
         2'd3: w_byte = i_word[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
   end

   // Extend the selected lane to a full word; invalid size yields zero.
   always_comb begin
      o_load_data = 32'h0;
      unique case (i_size)
         SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
         SZ_WORD: o_load_data = i_word;
         default: o_load_data = 32'h0;
      endcase
   end

   // Replace the target lane of the read word with the low bits of the store data.
   always_comb begin
      o_merged = i_word;
      unique case (i_size)
         SZ_BYTE: begin
            unique case (i_offset)
               2'd0: o_merged[7:0]   = i_wdata[7:0];
               2'd1: o_merged[15:8]  = i_wdata[7:0];
               2'd2: o_merged[23:16] = i_wdata[7:0];
               2'd3: o_merged[31:24] = i_wdata[7:0];
               default: o_merged = i_word;
            endcase
         end
         SZ_HALF: begin
            if (i_offset[1]) begin
               o_merged[31:16] = i_wdata[15:0];
            end else begin
               o_merged[15:0] = i_wdata[15:0];
            end
         end
         SZ_WORD: o_merged = i_wdata;
         default: o_merged = i_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed byte/half/word requests into full-word
// memory accesses, with read-modify-write for sub-word stores and error flagging
// for misaligned, out-of-range or invalid-size requests.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDX_W = 6
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_signed,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_mem_we,
   input  logic [31:0] i_mem_rdata
);

   lsu_state_e r_state;
   lsu_state_e w_state_d;

   logic [1:0]  r_offset;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_wdata;

   logic        r_rsp_valid;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_mem_we;

   logic        w_accept;
   logic        w_out_of_range;
   logic        w_err;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   // Word index must fall inside the memory; DEPTH is a power of two so this
   // is the same as requiring the address bits above the index to be zero.
   assign w_out_of_range = (i_req_addr[31:2] >= 30'(DEPTH));
   assign w_err          = is_bad_align(i_req_size, i_req_addr[1:0]) | w_out_of_range;
   assign w_accept       = i_req_valid && (r_state == IDLE);

   lsu_lane_unit u_lane (
      .i_word      (i_mem_rdata),
      .i_wdata     (r_wdata),
      .i_size      (r_size),
      .i_offset    (r_offset),
      .i_signed    (r_signed),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   // Next-state decode; the request type is dispatched on the acceptance edge.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         IDLE: begin
            if (i_req_valid) begin
               if (w_err) begin
                  w_state_d = RESP;
               end else if (!i_req_write) begin
                  w_state_d = LOAD;
               end else if (i_req_size == SZ_WORD) begin
                  w_state_d = WRITE;
               end else begin
                  w_state_d = RMW_RD;
               end
            end
         end
         LOAD:    w_state_d = RESP;
         RMW_RD:  w_state_d = WRITE;
         WRITE:   w_state_d = RESP;
         RESP:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Request latch and registered outputs; strobes default low each cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_offset    <= 2'b00;
         r_size      <= SZ_INVALID;
         r_signed    <= 1'b0;
         r_wdata     <= 32'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_err   <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_mem_we    <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_mem_we    <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_offset    <= i_req_addr[1:0];
                  r_size      <= i_req_size;
                  r_signed    <= i_req_signed;
                  r_wdata     <= i_req_wdata;
                  r_rsp_rdata <= 32'h0;
                  r_rsp_err   <= w_err;
                  if (w_err) begin
                     // Errors respond on the next cycle without touching memory.
                     r_rsp_valid <= 1'b1;
                  end else begin
                     r_mem_addr <= 32'(i_req_addr[IDX_W+1:2]);
                     if (i_req_write && (i_req_size == SZ_WORD)) begin
                        r_mem_wdata <= i_req_wdata;
                        r_mem_we    <= 1'b1;
                     end
                  end
               end
            end
            LOAD: begin
               r_rsp_rdata <= w_load_data;
               r_rsp_valid <= 1'b1;
            end
            RMW_RD: begin
               r_mem_wdata <= w_merged;
               r_mem_we    <= 1'b1;
            end
            WRITE: begin
               r_rsp_valid <= 1'b1;
            end
            RESP: begin
               r_rsp_valid <= 1'b0;
            end
            default: begin
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_req_ready = (r_state == IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_rsp_err   = r_rsp_err;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = r_mem_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [64];
   int          we_cnt = 0;
   logic [31:0] last_addr = 32'h0;
   logic [31:0] last_wdata = 32'h0;
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx = 6'd0;
   logic [31:0] pre_data = 32'h0;

   always #5 clk = ~clk;

   load_store_unit #(.DEPTH(64), .IDX_W(6)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_write  (req_write),
      .i_req_size   (req_size),
      .i_req_signed (req_signed),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_err    (rsp_err),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .o_mem_we     (mem_we),
      .i_mem_rdata  (mem_rdata)
   );

   // Word memory: combinational read, write on clock edge; bench preload port.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[5:0]] <= mem_wdata;
         we_cnt             <= we_cnt + 1;
         last_addr          <= mem_addr;
         last_wdata         <= mem_wdata;
      end else if (pre_en) begin
         mem[pre_idx] <= pre_data;
      end
   end
   assign mem_rdata = mem[mem_addr[5:0]];

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = idx;
      pre_data = data;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   // Issue one request; lat counts falling edges from acceptance to rsp_valid.
   task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
      @(negedge clk);
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat   = 0;
      rdata = 32'hDEAD_BEEF;
      err   = 1'bx;
      repeat (8) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) begin
            rdata = rsp_rdata;
            err   = rsp_err;
            break;
         end
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          we0;
   logic        saw_rsp;

   initial begin
      for (int i = 0; i < 64; i++) begin
         preload(6'(i), 32'h0);
      end
      preload(6'd0, 32'h1122_3344);
      preload(6'd1, 32'h8899_AABB);
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;

      // Loads.
      we0 = we_cnt;
      do_req(1'b0, SZ_BYTE, 1'b1, 32'h5, 32'h0, rd, er, lat);
      check("lb_s_5_data", rd, 32'hFFFF_FFAA);
      check("lb_s_5_err", 32'(er), 32'd0);
      check("lb_s_5_lat", 32'(lat), 32'd2);
      do_req(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, rd, er, lat);
      check("lh_u_6_data", rd, 32'h0000_8899);
      check("lh_u_6_lat", 32'(lat), 32'd2);
      do_req(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, rd, er, lat);
      check("lh_s_6_data", rd, 32'hFFFF_8899);
      do_req(1'b0, SZ_WORD, 1'b1, 32'h4, 32'h0, rd, er, lat);
      check("lw_4_data", rd, 32'h8899_AABB);
      do_req(1'b0, SZ_BYTE, 1'b0, 32'h4, 32'h0, rd, er, lat);
      check("lb_u_4_data", rd, 32'h0000_00BB);
      check("load_no_we", 32'(we_cnt - we0), 32'd0);

      // Byte store via read-modify-write.
      we0 = we_cnt;
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h7, 32'h1234_5677, rd, er, lat);
      check("sb_7_lat", 32'(lat), 32'd3);
      check("sb_7_err", 32'(er), 32'd0);
      check("sb_7_rdata", rd, 32'h0);
      check("sb_7_we_cnt", 32'(we_cnt - we0), 32'd1);
      check("sb_7_mem_addr", last_addr, 32'h1);
      check("sb_7_mem_wdata", last_wdata, 32'h7799_AABB);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
      check("sb_7_reload", rd, 32'h7799_AABB);

      // Word store, then half store into the upper lane of the same word.
      we0 = we_cnt;
      do_req(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hCAFE_F00D, rd, er, lat);
      check("sw_8_lat", 32'(lat), 32'd2);
      check("sw_8_mem_addr", last_addr, 32'h2);
      check("sw_8_mem_wdata", last_wdata, 32'hCAFE_F00D);
      do_req(1'b1, SZ_HALF, 1'b1, 32'hA, 32'hFFFF_1234, rd, er, lat);
      check("sh_a_lat", 32'(lat), 32'd3);
      check("sh_a_mem_wdata", last_wdata, 32'h1234_F00D);
      check("store_we_cnt", 32'(we_cnt - we0), 32'd2);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, rd, er, lat);
      check("sh_a_reload", rd, 32'h1234_F00D);

      // Error cases: one-cycle response, zero data, no memory write.
      we0 = we_cnt;
      do_req(1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, rd, er, lat);
      check("err_lh_3_err", 32'(er), 32'd1);
      check("err_lh_3_rdata", rd, 32'h0);
      check("err_lh_3_lat", 32'(lat), 32'd1);
      do_req(1'b1, SZ_WORD, 1'b0, 32'h102, 32'h5555_AAAA, rd, er, lat);
      check("err_sw_102_err", 32'(er), 32'd1);
      check("err_sw_102_lat", 32'(lat), 32'd1);
      do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, rd, er, lat);
      check("err_sz0_err", 32'(er), 32'd1);
      check("err_sz0_rdata", rd, 32'h0);
      check("err_sz0_lat", 32'(lat), 32'd1);
      do_req(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'hFF, rd, er, lat);
      check("err_oor_100_err", 32'(er), 32'd1);
      check("err_no_we", 32'(we_cnt - we0), 32'd0);

      // Reset while in RMW_RD abandons the half store.
      we0 = we_cnt;
      @(negedge clk);
      check("rmw_rst_ready0", 32'(req_ready), 32'd1);
      req_write  = 1'b1;
      req_size   = SZ_HALF;
      req_signed = 1'b0;
      req_addr   = 32'h4;
      req_wdata  = 32'h0000_BEEF;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw_busy", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rmw_rst_ready", 32'(req_ready), 32'd1);
      check("rmw_rst_we", 32'(mem_we), 32'd0);
      check("rmw_rst_mem_addr", mem_addr, 32'h0);
      saw_rsp = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid || mem_we) saw_rsp = 1'b1;
      end
      check("rmw_rst_quiet", 32'(saw_rsp), 32'd0);
      check("rmw_rst_we_cnt", 32'(we_cnt - we0), 32'd0);
      do_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, rd, er, lat);
      check("rmw_rst_unchanged", rd, 32'h7799_AABB);

      // req_valid held across two loads; the second is taken only after RESP and IDLE.
      @(negedge clk);
      req_write  = 1'b0;
      req_size   = SZ_WORD;
      req_signed = 1'b0;
      req_addr   = 32'h4;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("b2b_n1_ready", 32'(req_ready), 32'd0);
      check("b2b_n1_rsp", 32'(rsp_valid), 32'd0);
      req_addr = 32'h0;
      @(negedge clk);
      check("b2b_n2_rsp", 32'(rsp_valid), 32'd1);
      check("b2b_n2_rdata", rsp_rdata, 32'h7799_AABB);
      check("b2b_n2_ready", 32'(req_ready), 32'd0);
      check("b2b_n2_mem_addr", mem_addr, 32'h1);
      @(negedge clk);
      check("b2b_n3_ready", 32'(req_ready), 32'd1);
      check("b2b_n3_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_n4_ready", 32'(req_ready), 32'd0);
      check("b2b_n4_mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      check("b2b_n5_rsp", 32'(rsp_valid), 32'd1);
      check("b2b_n5_rdata", rsp_rdata, 32'h1122_3344);
      @(negedge clk);
      check("b2b_pulse_end", 32'(rsp_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
